// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, field decode, and a 2-read/1-write register file.
// Optional write-through bypass on the read ports is enabled by defining ID_FORWARD_EN.
module id_stage #(
  parameter int NREG_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 CLR,
  input  logic [31:0]          IR,
  input  logic [31:0]          PC,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [NREG_LOG2-1:0] wb_rd,
  input  logic [31:0]          wb_data,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_ir,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [31:0]          imm_sext,
  output logic [31:0]          rs_data,
  output logic [31:0]          rt_data,
  output logic [31:0]          jaddr,
  output logic [31:0]          baddr
);

  localparam int NREG = 2 ** NREG_LOG2;

  logic [31:0] regs [NREG];

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] read_port(input logic [NREG_LOG2-1:0] idx);
    logic [31:0] r;
    r = '0;
    if (idx != '0) begin
`ifdef ID_FORWARD_EN
      if (wb_we && (wb_rd == idx)) r = wb_data;
      else                         r = regs[idx];
`else
      r = regs[idx];
`endif
    end
    return r;
  endfunction

  // IF/ID boundary: reset beats flush beats stall beats load
  always_ff @(posedge clk) begin
    if (CLR) begin
      id_valid <= 1'b0;
      id_ir    <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_ir    <= '0;
      id_pc    <= '0;
    end else if (!stall) begin
      id_valid <= 1'b1;
      id_ir    <= IR;
      id_pc    <= PC;
    end
  end

  // Writeback port is independent of stall/flush; reset suppresses a concurrent write
  always_ff @(posedge clk) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign opcode   = id_ir[31:26];
  assign rs       = id_ir[25:21];
  assign rt       = id_ir[20:16];
  assign rd       = id_ir[15:11];
  assign funct    = id_ir[5:0];
  assign imm_sext = sext16(id_ir[15:0]);
  assign jaddr    = {6'b0, id_ir[25:0]};
  assign baddr    = id_pc + 32'd1 + imm_sext;

  assign rs_data = id_valid ? read_port(rs[NREG_LOG2-1:0]) : '0;
  assign rt_data = id_valid ? read_port(rt[NREG_LOG2-1:0]) : '0;

endmodule

// File: tb/tb_id_stage.sv
// Randomized and directed bench for id_stage against a behavioural pipeline/register-file model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        CLR, stall, flush, wb_we;
  logic [31:0] IR, PC, wb_data;
  logic [4:0]  wb_rd;
  logic        id_valid;
  logic [31:0] id_pc, id_ir, imm_sext, rs_data, rt_data, jaddr, baddr;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  opcode, funct;

  id_stage #(.NREG_LOG2(5)) dut (
    .clk(clk), .CLR(CLR), .IR(IR), .PC(PC), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .rs(rs), .rt(rt), .rd(rd), .opcode(opcode), .funct(funct),
    .imm_sext(imm_sext), .rs_data(rs_data), .rt_data(rt_data),
    .jaddr(jaddr), .baddr(baddr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 0;

  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_ir, m_pc;

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (!m_valid || idx == 0) return 32'd0;
    if (FWD && wb_we && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic drive(input logic c, input logic [31:0] ir_v, input logic [31:0] pc_v,
                       input logic st, input logic fl, input logic we,
                       input logic [4:0] rdx, input logic [31:0] d);
    CLR = c; IR = ir_v; PC = pc_v; stall = st; flush = fl;
    wb_we = we; wb_rd = rdx; wb_data = d;
  endtask

  task automatic model_check();
    logic [31:0] ir_s;
    ir_s = m_ir;
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("id_ir", id_ir, m_ir);
    chk("id_pc", id_pc, m_pc);
    chk("rs", {27'd0, rs}, (m_ir >> 21) & 32'h1F);
    chk("rt", {27'd0, rt}, (m_ir >> 16) & 32'h1F);
    chk("rd", {27'd0, rd}, (m_ir >> 11) & 32'h1F);
    chk("opcode", {26'd0, opcode}, m_ir >> 26);
    chk("funct", {26'd0, funct}, m_ir & 32'h3F);
    chk("imm_sext", imm_sext, ir_s[15] ? (32'hFFFF0000 | (m_ir & 32'hFFFF)) : (m_ir & 32'hFFFF));
    chk("jaddr", jaddr, m_ir & 32'h03FFFFFF);
    chk("baddr", baddr, m_pc + 32'd1 + (ir_s[15] ? (32'hFFFF0000 | (m_ir & 32'hFFFF)) : (m_ir & 32'hFFFF)));
    chk("rs_data", rs_data, m_read(5'((m_ir >> 21) & 32'h1F)));
    chk("rt_data", rt_data, m_read(5'((m_ir >> 16) & 32'h1F)));
  endtask

  // One clock: compare against model mid-cycle, then advance model on the edge
  task automatic cyc();
    @(negedge clk);
    if (armed) model_check();
    @(posedge clk);
    if (CLR) begin
      m_valid = 0; m_ir = 0; m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      armed = 1;
    end else begin
      if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
      if (flush) begin
        m_valid = 0; m_ir = 0; m_pc = 0;
      end else if (!stall) begin
        m_valid = 1; m_ir = IR; m_pc = PC;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] a, r;
    drive(1, 32'h0, 32'h0, 0, 0, 1, 5'd3, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    cyc(); cyc();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ir", id_ir, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_rs_data", rs_data, 32'd0);

    drive(0, 32'h8C220004, 32'd7, 0, 0, 0, 5'd0, 32'd0); cyc();
    chk("lw_valid", {31'd0, id_valid}, 32'd1);
    chk("lw_rs", {27'd0, rs}, 32'd1);
    chk("lw_rt", {27'd0, rt}, 32'd2);
    chk("lw_rd", {27'd0, rd}, 32'd0);
    chk("lw_funct", {26'd0, funct}, 32'd4);
    chk("lw_opcode", {26'd0, opcode}, 32'h23);
    chk("lw_imm", imm_sext, 32'd4);
    chk("lw_baddr", baddr, 32'd12);

    drive(0, 32'h00A00000, 32'd20, 0, 0, 1, 5'd5, 32'hDEADBEEF); cyc();
    chk("r5_rs_data", rs_data, 32'hDEADBEEF);
    chk("r5_rt_data", rt_data, 32'd0);
    drive(0, 32'h0, 32'd0, 1, 0, 1, 5'd0, 32'h1234); cyc();
    chk("r0_rt_data", rt_data, 32'd0);
    chk("r0_hold_rs", rs_data, 32'hDEADBEEF);

    a = 32'h12345678;
    drive(0, a, 32'd100, 0, 0, 0, 5'd0, 32'd0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, $urandom, $urandom, 1, 0, 0, 5'd0, 32'd0); cyc();
      chk("stall_ir", id_ir, a);
    end
    drive(0, $urandom, $urandom, 1, 1, 0, 5'd0, 32'd0); cyc();
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_ir", id_ir, 32'd0);

    drive(0, 32'h0000FFFF, 32'd0, 0, 0, 0, 5'd0, 32'd0); cyc();
    chk("neg_imm", imm_sext, 32'hFFFFFFFF);
    chk("neg_baddr", baddr, 32'd0);
    drive(0, 32'h0BFFFFFF, 32'd0, 0, 0, 0, 5'd0, 32'd0); cyc();
    chk("jaddr_max", jaddr, 32'h03FFFFFF);

    drive(0, 32'h01200000, 32'd0, 0, 0, 1, 5'd9, 32'h11); cyc();
    drive(0, 32'h0, 32'd0, 1, 0, 1, 5'd9, 32'h55);
    #2;
    chk("fwd_same_cycle", rs_data, FWD ? 32'h55 : 32'h11);
    cyc();
    chk("fwd_after_edge", rs_data, 32'h55);

    drive(1, 32'h0, 32'd0, 1, 1, 1, 5'd3, 32'h77); cyc();
    chk("clr_wr_valid", {31'd0, id_valid}, 32'd0);
    drive(0, 32'h00600000, 32'd0, 0, 0, 0, 5'd0, 32'd0); cyc();
    chk("clr_wr_r3", rs_data, 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      wb_rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r[25:21] = wb_rd;
      drive(($urandom_range(0, 31) == 0), r, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 1), wb_rd, $urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
